button_pulse_shaper: RTL and testbench

- Converts long, bouncy push-button levels from the player front panel into clean single-cycle event pulses: press, release and auto-repeat while held.
- Sits between the raw board button pins and the player control FSM (play/pause, next, prev, volume).
- It is the inverse of the pulse stretcher, which widens one-cycle pulses into long ones. This block reduces long levels to one-cycle pulses.
- NUM_BTN identical, fully independent channels.

---
 rtl/button_pulse_shaper.sv | 140 ++++++++++++++
 tb/tb_button_pulse_shaper.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/button_pulse_shaper.sv
// rtl/button_pulse_shaper.sv - debounces raw button levels into press, release and auto-repeat pulses
module button_pulse_shaper #(
  parameter int NUM_BTN       = 4,
  parameter int DEB_CYCLES    = 16,
  parameter int HOLD_CYCLES   = 5000,
  parameter int REPEAT_CYCLES = 1000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse,
  output logic [NUM_BTN-1:0] held
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_REPEAT,
    ST_RELEASE_DB
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] btn_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= '0;
      btn_s <= '0;
    end else begin
      s1    <= btn_raw;
      btn_s <= s1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             press_r;
    logic             release_r;
    logic             repeat_r;
    logic             held_r;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        repeat_r  <= 1'b0;
        held_r    <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        repeat_r  <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (btn_s[i]) begin
              state <= ST_PRESS_DB;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= '0;
            end
          end
          ST_PRESS_DB: begin
            if (!btn_s[i]) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state   <= ST_HELD;
              cnt     <= '0;
              press_r <= 1'b1;
              held_r  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_HELD: begin
            if (!btn_s[i]) begin
              state <= ST_RELEASE_DB;
              cnt   <= CNT_ONE;
            end else if (REPEAT_EN && cnt == HOLD_LAST) begin
              state    <= ST_REPEAT;
              cnt      <= '0;
              repeat_r <= 1'b1;
            end else if (cnt != HOLD_LAST) begin
              // parks at the terminal value when auto-repeat is disabled
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_REPEAT: begin
            if (!btn_s[i]) begin
              state <= ST_RELEASE_DB;
              cnt   <= CNT_ONE;
            end else if (cnt == REPEAT_LAST) begin
              cnt      <= '0;
              repeat_r <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_RELEASE_DB: begin
            if (btn_s[i]) begin
              // release bounce: back to HELD with hold timing restarted
              state <= ST_HELD;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state     <= ST_IDLE;
              cnt       <= '0;
              release_r <= 1'b1;
              held_r    <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state  <= ST_IDLE;
            cnt    <= '0;
            held_r <= 1'b0;
          end
        endcase
      end
    end

    assign press_pulse[i]   = press_r;
    assign release_pulse[i] = release_r;
    assign repeat_pulse[i]  = repeat_r;
    assign held[i]          = held_r;
  end

endmodule

// File: tb/tb_button_pulse_shaper.sv
// tb/tb_button_pulse_shaper.sv - directed bench with a run-length/timestamp reference model
module tb_button_pulse_shaper;

  localparam int NB   = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 5;
  localparam bit REN  = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] press_pulse, release_pulse, repeat_pulse, held;

  int n_cmp = 0;
  int n_bad = 0;

  button_pulse_shaper #(
    .NUM_BTN(NB), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .REPEAT_EN(REN), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .held(held)
  );

  always #5 clk = ~clk;

  // Reference: pulses derived from run lengths of the synchronized level and
  // the time elapsed since hold timing last (re)started.
  logic [NB-1:0] m_s1, m_s2, m_in;
  logic [NB-1:0] e_press, e_release, e_repeat, e_held;
  int run_hi [NB];
  int run_lo [NB];
  int anchor [NB];
  int edge_no;

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; edge_no = 0;
    e_press = '0; e_release = '0; e_repeat = '0; e_held = '0;
    for (int i = 0; i < NB; i++) begin
      run_hi[i] = 0; run_lo[i] = 0; anchor[i] = 0;
    end
  endtask

  task automatic m_step();
    int el;
    m_in = m_s2; m_s2 = m_s1; m_s1 = btn_raw;
    edge_no++;
    e_press = '0; e_release = '0; e_repeat = '0;
    for (int i = 0; i < NB; i++) begin
      if (m_in[i]) begin run_hi[i]++; run_lo[i] = 0; end
      else begin run_lo[i]++; run_hi[i] = 0; end
      if (!e_held[i]) begin
        if (run_hi[i] == DEB) begin
          e_press[i] = 1'b1; e_held[i] = 1'b1; anchor[i] = edge_no;
        end
      end else if (!m_in[i]) begin
        if (run_lo[i] == DEB) begin
          e_release[i] = 1'b1; e_held[i] = 1'b0;
        end
      end else if (run_hi[i] == 1) begin
        anchor[i] = edge_no;
      end else begin
        el = edge_no - anchor[i];
        if (REN && el >= HOLD && (el - HOLD) % REP == 0) e_repeat[i] = 1'b1;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      n_cmp++;
      if ({press_pulse, release_pulse, repeat_pulse, held} !==
          {e_press, e_release, e_repeat, e_held}) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t got p/r/rp/h=%b/%b/%b/%b exp=%b/%b/%b/%b", $time,
                 press_pulse, release_pulse, repeat_pulse, held,
                 e_press, e_release, e_repeat, e_held);
      end
    end
  end

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
    end
  endtask

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    go(3);
    check("reset_outputs", press_pulse | release_pulse | repeat_pulse | held, 2'b00);
    rst = 1'b0;
    go(2);

    // clean press, auto-repeat, release
    btn_raw = 2'b01;
    go(5); check("press_early", press_pulse, 2'b00);
    go(1); check("press_edge5", press_pulse, 2'b01);
    check("held_after_press", held, 2'b01);
    go(1); check("press_one_cycle", press_pulse, 2'b00);
    go(9); check("repeat_edge15", repeat_pulse, 2'b01);
    go(5); check("repeat_edge20", repeat_pulse, 2'b01);
    btn_raw = 2'b00;
    go(5); check("held_before_rel", held, 2'b01);
    check("rel_early", release_pulse, 2'b00);
    go(1); check("release_edge", release_pulse, 2'b01);
    check("held_drops", held, 2'b00);
    go(10);

    // release bounce restarts hold timing
    btn_raw = 2'b01;
    go(6); check("press_again", press_pulse, 2'b01);
    btn_raw = 2'b00;
    go(2);
    btn_raw = 2'b01;
    go(12); check("no_repeat_yet", repeat_pulse, 2'b00);
    check("still_held", held, 2'b01);
    go(1); check("repeat_after_reentry", repeat_pulse, 2'b01);
    btn_raw = 2'b00;
    go(12);

    // press bounce: 2 high, 1 low, then steady
    btn_raw = 2'b01;
    go(2);
    btn_raw = 2'b00;
    go(1);
    btn_raw = 2'b01;
    go(5); check("bounce_no_press", press_pulse, 2'b00);
    go(1); check("bounce_press", press_pulse, 2'b01);
    btn_raw = 2'b00;
    go(12);

    // two channels together, then release only channel 1
    btn_raw = 2'b11;
    go(6); check("multi_press", press_pulse, 2'b11);
    btn_raw = 2'b01;
    go(6); check("multi_release", release_pulse, 2'b10);
    check("multi_held", held, 2'b01);
    go(6);

    // reset while channel 0 repeats, button still down afterwards
    rst = 1'b1;
    #1; check("reset_immediate", press_pulse | release_pulse | repeat_pulse | held, 2'b00);
    go(2);
    rst = 1'b0;
    go(5); check("post_reset_no_press", press_pulse, 2'b00);
    check("post_reset_no_release", release_pulse, 2'b00);
    go(1); check("post_reset_press", press_pulse, 2'b01);
    btn_raw = 2'b00;
    go(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
